// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 NPC core: sequencer states,
// reset constants and base opcodes used by the decoder.
package ysyx_23060187_pkg;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_IMM    = 7'b001_0011;
   localparam logic [6:0] OP_REG    = 7'b011_0011;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;
   localparam logic [6:0] OP_JALR   = 7'b110_0111;
   localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/ysyx_23060187_wdog.sv
// Bus-wait watchdog: counts enabled cycles up to WDOG_MAX and flags the
// cycle on which the limit would be reached while still waiting.
module ysyx_23060187_wdog #(
   parameter int unsigned WDOG_MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(WDOG_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CW'(WDOG_MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // A ready in the limit cycle drops en_i, so it wins over the error.
   assign expire_o = en_i && (cnt_q == CW'(WDOG_MAX - 1));

endmodule

// File: rtl/ysyx_23060187_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB/HALT sequencer: owns PC, instruction
// register, request handshakes, retire/cycle counters and the watchdog.
import ysyx_23060187_pkg::*;

module ysyx_23060187_seq_ctrl #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned     WDOG_MAX = 255
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifu_req,
   output logic [XLEN-1:0] ifu_addr,
   input  logic            ifu_ready,
   input  logic [31:0]     ifu_rdata,
   output logic [31:0]     inst,
   input  logic            dec_mem,
   input  logic            dec_rd_wen,
   input  logic            dec_ebreak,
   input  logic [XLEN-1:0] next_pc,
   output logic            lsu_req,
   input  logic            lsu_ready,
   output logic            rf_wen,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic            halted,
   output logic            bus_err,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
);

   state_e          state_q, state_d;
   logic            ifu_req_q, ifu_req_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic [31:0]     inst_q, inst_d;
   logic            mem_q, mem_d;
   logic            wen_q, wen_d;
   logic            ebr_q, ebr_d;
   logic            bus_err_q, bus_err_d;
   logic [63:0]     cycle_q, cycle_d;
   logic [63:0]     instret_q, instret_d;
   logic            fetch_hs;
   logic            wd_en;
   logic            wd_clr;
   logic            wd_expire;

   // ifu_ready only counts while our registered request is actually up.
   assign fetch_hs = ifu_req_q && ifu_ready;
   assign wd_en    = ((state_q == S_FETCH) && ifu_req_q && !ifu_ready) ||
                     ((state_q == S_MEM) && !lsu_ready);
   assign wd_clr   = (state_d != state_q);

   ysyx_23060187_wdog #(
      .WDOG_MAX (WDOG_MAX)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      npc_d     = npc_q;
      inst_d    = inst_q;
      mem_d     = mem_q;
      wen_d     = wen_q;
      ebr_d     = ebr_q;
      bus_err_d = bus_err_q;
      cycle_d   = cycle_q + 64'd1;
      instret_d = instret_q;
      lsu_req   = 1'b0;
      rf_wen    = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (fetch_hs) begin
               inst_d  = ifu_rdata;
               state_d = S_EXEC;
            end else if (wd_expire) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_EXEC: begin
            mem_d   = dec_mem;
            wen_d   = dec_rd_wen;
            ebr_d   = dec_ebreak;
            npc_d   = next_pc;
            state_d = dec_mem ? S_MEM : S_WB;
         end
         S_MEM: begin
            lsu_req = 1'b1;
            if (lsu_ready) begin
               state_d = S_WB;
            end else if (wd_expire) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            rf_wen    = wen_q;
            retire    = 1'b1;
            pc_d      = npc_q;
            instret_d = instret_q + 64'd1;
            state_d   = ebr_q ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
         end
      endcase
      ifu_req_d = (state_d == S_FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ifu_req_q <= 1'b0;
         pc_q      <= RESET_PC;
         npc_q     <= RESET_PC;
         inst_q    <= NOP_INST;
         mem_q     <= 1'b0;
         wen_q     <= 1'b0;
         ebr_q     <= 1'b0;
         bus_err_q <= 1'b0;
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         state_q   <= state_d;
         ifu_req_q <= ifu_req_d;
         pc_q      <= pc_d;
         npc_q     <= npc_d;
         inst_q    <= inst_d;
         mem_q     <= mem_d;
         wen_q     <= wen_d;
         ebr_q     <= ebr_d;
         bus_err_q <= bus_err_d;
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign ifu_req     = ifu_req_q;
   assign ifu_addr    = pc_q;
   assign pc          = pc_q;
   assign inst        = inst_q;
   assign bus_err     = bus_err_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule
